// File: rtl/exe_pkg.sv
// Shared definitions for the matrix execution engine decode stage:
// instruction field positions, opcode values, source/destination encodings
// and the packed control vector driven onto the data path.
package exe_pkg;

  // Instruction layout: [4] = destination, [3] = source, [2:0] = op
  localparam int INSTR_W  = 5;
  localparam int DEST_BIT = 4;
  localparam int SRC_BIT  = 3;
  localparam int OP_MSB   = 2;
  localparam int OP_LSB   = 0;

  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_MOVE      = 3'b001;
  localparam logic [2:0] OP_ADD       = 3'b010;
  localparam logic [2:0] OP_SUB       = 3'b011;
  localparam logic [2:0] OP_SCALE     = 3'b100;
  localparam logic [2:0] OP_MULT      = 3'b101;
  localparam logic [2:0] OP_TRANSPOSE = 3'b110;
  localparam logic [2:0] OP_RSVD      = 3'b111;

  localparam logic DEST_REG = 1'b0;
  localparam logic DEST_MEM = 1'b1;
  localparam logic SRC_MEM  = 1'b0;
  localparam logic SRC_REG  = 1'b1;

  // Control vector, MSB first in the order the outputs are declared
  typedef struct packed {
    logic read_from;
    logic write_to_reg;
    logic write_to_mem;
    logic add_en;
    logic scale_en;
    logic mult_en;
    logic transpose_en;
    logic add_or_sub;
  } ctrl_t;

endpackage

// File: rtl/exe_decode.sv
// Combinational instruction decode: maps a 5-bit instruction onto the
// control vector. NOP, reserved and unknown encodings yield all zeros.
module exe_decode
  import exe_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output ctrl_t              ctrl_o
);

  logic [OP_MSB:OP_LSB] op;
  logic                 src;
  logic                 dest;

  assign op   = instr_i[OP_MSB:OP_LSB];
  assign src  = instr_i[SRC_BIT];
  assign dest = instr_i[DEST_BIT];

  // Decode op into unit enables; routing bits only for real operations
  always_comb begin
    ctrl_o = '0;
    case (op)
      OP_NOP, OP_RSVD: begin
        ctrl_o = '0;
      end
      OP_MOVE, OP_ADD, OP_SUB, OP_SCALE, OP_MULT, OP_TRANSPOSE: begin
        ctrl_o.read_from    = (src != SRC_MEM);
        ctrl_o.write_to_reg = (dest == DEST_REG);
        ctrl_o.write_to_mem = (dest == DEST_MEM);
        ctrl_o.add_en       = (op == OP_ADD) || (op == OP_SUB);
        ctrl_o.add_or_sub   = (op == OP_SUB);
        ctrl_o.scale_en     = (op == OP_SCALE);
        ctrl_o.mult_en      = (op == OP_MULT);
        ctrl_o.transpose_en = (op == OP_TRANSPOSE);
      end
      // Unknown bits fall through here and decode as NOP
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/exe_engine.sv
// Instruction decode stage: combinational decode followed by a single
// asynchronously reset output register bank, giving one cycle of latency.
module exe_engine
  import exe_pkg::*;
(
  output logic               read_from,
  output logic               write_to_reg,
  output logic               write_to_mem,
  output logic               add_en,
  output logic               scale_en,
  output logic               mult_en,
  output logic               transpose_en,
  output logic               add_or_sub,
  input  logic [INSTR_W-1:0] instr,
  input  logic               reset,
  input  logic               clk
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  exe_decode u_decode (
    .instr_i (instr),
    .ctrl_o  (ctrl_d)
  );

  // Register the decoded strobes; reset clears them without waiting for clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign read_from    = ctrl_q.read_from;
  assign write_to_reg = ctrl_q.write_to_reg;
  assign write_to_mem = ctrl_q.write_to_mem;
  assign add_en       = ctrl_q.add_en;
  assign scale_en     = ctrl_q.scale_en;
  assign mult_en      = ctrl_q.mult_en;
  assign transpose_en = ctrl_q.transpose_en;
  assign add_or_sub   = ctrl_q.add_or_sub;

endmodule

// File: tb/tb_exe_engine.sv
// Directed bench for the execution engine decode stage.
// Vector order: {read_from, write_to_reg, write_to_mem, add_en,
//                scale_en, mult_en, transpose_en, add_or_sub}
module tb_exe_engine;

  logic       clk;
  logic       reset;
  logic [4:0] instr;
  logic       read_from, write_to_reg, write_to_mem, add_en;
  logic       scale_en, mult_en, transpose_en, add_or_sub;
  logic [7:0] obs;

  int tests;
  int fails;

  exe_engine dut (
    .read_from    (read_from),
    .write_to_reg (write_to_reg),
    .write_to_mem (write_to_mem),
    .add_en       (add_en),
    .scale_en     (scale_en),
    .mult_en      (mult_en),
    .transpose_en (transpose_en),
    .add_or_sub   (add_or_sub),
    .instr        (instr),
    .reset        (reset),
    .clk          (clk)
  );

  assign obs = {read_from, write_to_reg, write_to_mem, add_en,
                scale_en, mult_en, transpose_en, add_or_sub};

  // Rising edges at 10, 20, 30 ... ns; falling edges at 5, 15, 25 ... ns
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Reference decode written from the opcode table
  function automatic logic [7:0] model(input logic [4:0] ins);
    logic [2:0] op;
    logic [7:0] v;
    op = ins[2:0];
    v  = 8'h00;
    if (op != 3'b000 && op != 3'b111) begin
      v[7] = ins[3];
      v[6] = ~ins[4];
      v[5] = ins[4];
      case (op)
        3'b010:  v[4] = 1'b1;
        3'b011:  begin v[4] = 1'b1; v[0] = 1'b1; end
        3'b100:  v[3] = 1'b1;
        3'b101:  v[2] = 1'b1;
        3'b110:  v[1] = 1'b1;
        default: ;
      endcase
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check_inv(input string tag);
    tests++;
    assert ($onehot0({add_en, scale_en, mult_en, transpose_en})) else begin
      fails++;
      $error("FAIL %s onehot observed=%b expected=onehot0", tag,
             {add_en, scale_en, mult_en, transpose_en});
    end
    tests++;
    assert (!(write_to_reg && write_to_mem)) else begin
      fails++;
      $error("FAIL %s wr_excl observed=%b%b expected=not 11", tag, write_to_reg, write_to_mem);
    end
    tests++;
    assert (!add_or_sub || add_en) else begin
      fails++;
      $error("FAIL %s sub_implies_add observed=%b%b expected=add_en when sub", tag,
             add_or_sub, add_en);
    end
  endtask

  // Drive an instruction 1ns after an edge, then sample 1ns after the next edge
  task automatic apply(input logic [4:0] ins);
    instr = ins;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    instr = 5'b10100;

    // Asynchronous reset between edges
    #5 reset = 1'b1;
    #1 check("reset_async", obs, 8'h00);
    #2 check("reset_held", obs, 8'h00);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 check("first_edge_after_reset", obs, 8'b0010_1000);

    // Hand-computed directed vectors
    apply(5'b00010); check("add_00010",   obs, 8'b0101_0000);
    apply(5'b11011); check("sub_11011",   obs, 8'b1011_0001);
    apply(5'b01001); check("move_01001",  obs, 8'b1100_0000);
    apply(5'b10001); check("move_10001",  obs, 8'b0010_0000);
    apply(5'b00100); check("scale_00100", obs, 8'b0100_1000);

    // NOP and reserved ignore the routing bits
    apply(5'b00000); check("nop_00000",  obs, 8'h00);
    apply(5'b11000); check("nop_11000",  obs, 8'h00);
    apply(5'b00111); check("rsvd_00111", obs, 8'h00);
    apply(5'b11111); check("rsvd_11111", obs, 8'h00);

    // Back-to-back latency
    apply(5'b01101); check("lat_mult",      obs, 8'b1100_0100);
    apply(5'b10110); check("lat_transpose", obs, 8'b0010_0010);

    // Full sweep including the 11111 -> 00000 wrap
    for (int i = 0; i < 33; i++) begin
      logic [4:0] v;
      v = 5'(i);
      apply(v);
      check($sformatf("sweep_%05b", v), obs, model(v));
      check_inv($sformatf("inv_sweep_%05b", v));
    end

    // Random instructions with invariants
    for (int i = 0; i < 40; i++) begin
      logic [4:0] v;
      v = 5'($urandom_range(0, 31));
      apply(v);
      check($sformatf("rand_%05b", v), obs, model(v));
      check_inv($sformatf("inv_rand_%05b", v));
    end

    // Reset pulse mid-operation, held across an edge
    apply(5'b10100); check("mid_scale", obs, 8'b0010_1000);
    #2 reset = 1'b1;
    #1 check("mid_reset_async", obs, 8'h00);
    @(posedge clk);
    #1 check("mid_reset_over_edge", obs, 8'h00);
    #2 reset = 1'b0;
    @(posedge clk);
    #1 check("mid_reset_reload", obs, 8'b0010_1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
